// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard/redirect bundle between the core stages and pipe_ctrl.
// master = the controller, slave = the pipeline stages.
interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        mem_access;
  logic        exc_valid;
  logic        eret;
  logic [31:0] epc_in;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        busy;
  logic        wdog_err;

  modport master (
    input  stallreq_id,
    input  stallreq_ex,
    input  mem_access,
    input  exc_valid,
    input  eret,
    input  epc_in,
    output stall,
    output flush,
    output new_pc,
    output busy,
    output wdog_err
  );

  modport slave (
    output stallreq_id,
    output stallreq_ex,
    output mem_access,
    output exc_valid,
    output eret,
    output epc_in,
    input  stall,
    input  flush,
    input  new_pc,
    input  busy,
    input  wdog_err
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall vector, MEM wait sequencer and flush/redirect control.
// Optional stall watchdog enabled by defining PIPE_WDOG_EN.
module pipe_ctrl #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] EXC_BASE    = 32'h0000_0020,
  parameter int          WDOG_LIMIT  = 255
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.master  bus
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEMWAIT  = 2'd1;
  localparam logic [1:0] REDIRECT = 2'd2;
  localparam logic [1:0] FLUSH    = 2'd3;

  localparam logic [5:0] ST_NONE = 6'b000000;
  localparam logic [5:0] ST_ID   = 6'b000111;
  localparam logic [5:0] ST_EX   = 6'b001111;
  localparam logic [5:0] ST_MEM  = 6'b011111;

  localparam logic [3:0] WLOAD = 4'(WAIT_CYCLES - 1);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("pipe_ctrl: WAIT_CYCLES out of range 0..15");
  end
  if (WDOG_LIMIT < 1 || WDOG_LIMIT > 65535) begin : g_bad_wdog
    $error("pipe_ctrl: WDOG_LIMIT out of range 1..65535");
  end

  logic [1:0]  state;
  logic [1:0]  state_d;
  logic [3:0]  wcnt;
  logic [3:0]  wcnt_d;
  logic [5:0]  stall_c;
  logic        take;
  logic        redir_req;
  logic [31:0] pc_next;
  logic        flush_q;
  logic [31:0] new_pc_q;

  assign redir_req = bus.exc_valid | bus.eret;
  // exc_valid outranks eret when both arrive together
  assign pc_next   = bus.exc_valid ? EXC_BASE : bus.epc_in;

  // next state, wait counter and raw stall vector
  always_comb begin
    state_d = state;
    wcnt_d  = wcnt;
    stall_c = ST_NONE;
    take    = 1'b0;
    case (state)
      RUN: begin
        if (redir_req) begin
          stall_c = ST_MEM;
          take    = 1'b1;
          state_d = REDIRECT;
        end else if (bus.mem_access && WAIT_CYCLES > 0) begin
          stall_c = ST_MEM;
          if (WAIT_CYCLES > 1) begin
            wcnt_d  = WLOAD;
            state_d = MEMWAIT;
          end
        end else if (bus.stallreq_ex) begin
          stall_c = ST_EX;
        end else if (bus.stallreq_id) begin
          stall_c = ST_ID;
        end
      end
      MEMWAIT: begin
        stall_c = ST_MEM;
        if (redir_req) begin
          take    = 1'b1;
          wcnt_d  = 4'd0;
          state_d = REDIRECT;
        end else begin
          wcnt_d = wcnt - 4'd1;
          if (wcnt == 4'd1) begin
            state_d = RUN;
          end
        end
      end
      REDIRECT: begin
        stall_c = ST_MEM;
        state_d = FLUSH;
      end
      FLUSH: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
        wcnt_d  = 4'd0;
      end
    endcase
  end

  // state, counter, flush pulse and redirect target registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      wcnt     <= 4'd0;
      flush_q  <= 1'b0;
      new_pc_q <= 32'd0;
    end else begin
      state   <= state_d;
      wcnt    <= wcnt_d;
      flush_q <= (state == REDIRECT);
      if (take) begin
        new_pc_q <= pc_next;
      end
    end
  end

  // stall is held at zero for as long as reset is asserted
  assign bus.stall  = rst ? stall_c : ST_NONE;
  assign bus.flush  = flush_q;
  assign bus.new_pc = new_pc_q;
  assign bus.busy   = (state != RUN);

`ifdef PIPE_WDOG_EN
  localparam logic [15:0] LIM = 16'(WDOG_LIMIT);

  logic [15:0] wd_cnt;
  logic        wd_err;

  // count consecutive PC-stall cycles, saturate, latch the timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= 16'd0;
      wd_err <= 1'b0;
    end else begin
      if (!bus.stall[0]) begin
        wd_cnt <= 16'd0;
      end else if (wd_cnt != LIM) begin
        wd_cnt <= wd_cnt + 16'd1;
      end
      if (bus.stall[0] && wd_cnt == LIM - 16'd1) begin
        wd_err <= 1'b1;
      end
    end
  end

  assign bus.wdog_err = wd_err;
`else
  assign bus.wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vectors for pipe_ctrl, WAIT_CYCLES=3, WDOG_LIMIT=4.
// Expected wdog_err follows whether PIPE_WDOG_EN is defined.
module tb_pipe_ctrl;

  logic clk;
  logic rst;
  int   errs;
  int   checks;

  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .WAIT_CYCLES (3),
    .EXC_BASE    (32'h0000_0020),
    .WDOG_LIMIT  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef PIPE_WDOG_EN
  localparam logic WD_EXP = 1'b1;
`else
  localparam logic WD_EXP = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic idle;
    bus.stallreq_id = 1'b0;
    bus.stallreq_ex = 1'b0;
    bus.mem_access  = 1'b0;
    bus.exc_valid   = 1'b0;
    bus.eret        = 1'b0;
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    rst    = 1'b0;
    idle();
    bus.epc_in = 32'h0000_1234;
    bus.stallreq_id = 1'b1;
    #3;
    chk("rst_stall", 32'(bus.stall), 32'h00);
    chk("rst_flush", 32'(bus.flush), 32'h0);
    chk("rst_newpc", bus.new_pc, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_wdog", 32'(bus.wdog_err), 32'h0);
    bus.stallreq_id = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();

    // single memory access: three stall cycles, busy on the last two
    bus.mem_access = 1'b1;
    mid();
    chk("mw0_stall", 32'(bus.stall), 32'h1F);
    chk("mw0_busy", 32'(bus.busy), 32'h0);
    tick();
    bus.mem_access = 1'b0;
    mid();
    chk("mw1_stall", 32'(bus.stall), 32'h1F);
    chk("mw1_busy", 32'(bus.busy), 32'h1);
    tick();
    mid();
    chk("mw2_stall", 32'(bus.stall), 32'h1F);
    chk("mw2_busy", 32'(bus.busy), 32'h1);
    tick();
    mid();
    chk("mw3_stall", 32'(bus.stall), 32'h00);
    chk("mw3_busy", 32'(bus.busy), 32'h0);
    tick();

    // stall request priority
    bus.stallreq_id = 1'b1;
    bus.stallreq_ex = 1'b1;
    mid();
    chk("idex_stall", 32'(bus.stall), 32'h0F);
    tick();
    bus.stallreq_ex = 1'b0;
    mid();
    chk("id_stall", 32'(bus.stall), 32'h07);
    tick();
    idle();

    // exception aborts a memory wait with wcnt=2
    bus.mem_access = 1'b1;
    tick();
    bus.mem_access = 1'b0;
    bus.exc_valid  = 1'b1;
    mid();
    chk("xw_stall0", 32'(bus.stall), 32'h1F);
    tick();
    bus.exc_valid = 1'b0;
    mid();
    chk("xw_stall1", 32'(bus.stall), 32'h1F);
    chk("xw_flush1", 32'(bus.flush), 32'h0);
    tick();
    mid();
    chk("xw_flush2", 32'(bus.flush), 32'h1);
    chk("xw_newpc", bus.new_pc, 32'h0000_0020);
    chk("xw_stall2", 32'(bus.stall), 32'h00);
    chk("xw_busy2", 32'(bus.busy), 32'h1);
    tick();
    mid();
    chk("xw_flush3", 32'(bus.flush), 32'h0);
    chk("xw_busy3", 32'(bus.busy), 32'h0);
    tick();

    // eret alone redirects to epc_in
    bus.eret   = 1'b1;
    bus.epc_in = 32'h0000_1234;
    mid();
    chk("er_stall0", 32'(bus.stall), 32'h1F);
    tick();
    bus.eret = 1'b0;
    mid();
    chk("er_stall1", 32'(bus.stall), 32'h1F);
    tick();
    mid();
    chk("er_flush", 32'(bus.flush), 32'h1);
    chk("er_newpc", bus.new_pc, 32'h0000_1234);
    tick();
    mid();
    chk("er_flush_end", 32'(bus.flush), 32'h0);
    tick();

    // exc+eret+mem together; exc held through REDIRECT/FLUSH is ignored
    bus.eret       = 1'b1;
    bus.exc_valid  = 1'b1;
    bus.mem_access = 1'b1;
    mid();
    chk("ee_stall0", 32'(bus.stall), 32'h1F);
    tick();
    bus.eret       = 1'b0;
    bus.mem_access = 1'b0;
    mid();
    chk("ee_stall1", 32'(bus.stall), 32'h1F);
    tick();
    mid();
    chk("ee_flush", 32'(bus.flush), 32'h1);
    chk("ee_newpc", bus.new_pc, 32'h0000_0020);
    chk("ee_stall2", 32'(bus.stall), 32'h00);
    tick();
    bus.exc_valid = 1'b0;
    mid();
    chk("ee_busy3", 32'(bus.busy), 32'h0);
    chk("ee_stall3", 32'(bus.stall), 32'h00);
    tick();

    // back-to-back accesses each get the full wait
    bus.mem_access = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mid();
      chk("bb_stall", 32'(bus.stall), 32'h1F);
      chk("bb_busy", 32'(bus.busy), ((i % 3) != 0) ? 32'h1 : 32'h0);
      tick();
    end
    bus.mem_access = 1'b0;
    mid();
    chk("bb_end", 32'(bus.stall), 32'h00);
    tick();

    // asynchronous reset in FLUSH
    bus.exc_valid = 1'b1;
    tick();
    bus.exc_valid = 1'b0;
    tick();
    chk("ar_flush_pre", 32'(bus.flush), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_flush", 32'(bus.flush), 32'h0);
    chk("ar_newpc", bus.new_pc, 32'h0);
    chk("ar_busy", 32'(bus.busy), 32'h0);
    bus.stallreq_id = 1'b1;
    #1;
    chk("ar_stall", 32'(bus.stall), 32'h00);
    chk("ar_wdog", 32'(bus.wdog_err), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    mid();
    chk("ar_id_stall", 32'(bus.stall), 32'h07);
    chk("ar_id_busy", 32'(bus.busy), 32'h0);
    tick();
    idle();
    tick();

    // watchdog: four stalled cycles reach the limit
    bus.stallreq_ex = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("wd_stall", 32'(bus.stall), 32'h0F);
      chk("wd_pre", 32'(bus.wdog_err), 32'h0);
      tick();
    end
    bus.stallreq_ex = 1'b0;
    chk("wd_set", 32'(bus.wdog_err), 32'(WD_EXP));
    mid();
    chk("wd_clear_stall", 32'(bus.stall), 32'h00);
    tick();
    tick();
    chk("wd_sticky", 32'(bus.wdog_err), 32'(WD_EXP));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
